// File: rtl/ping_pong_checker.sv
// Receive-side monitor for a ping-pong counter's {dir, value} stream: locks, flags errors,
// counts bounces. Optional PING_PONG_CHECKER_STICKY_EN adds err_clr / err_sticky.
module ping_pong_checker #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LOCK_N    = 2,
  parameter int unsigned ERR_CNT_W = 8,
  parameter int unsigned BNC_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_dir,
  input  logic [WIDTH-1:0]     in_value,
`ifdef PING_PONG_CHECKER_STICKY_EN
  input  logic                 err_clr,
  output logic                 err_sticky,
`endif
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 top_pulse,
  output logic                 bottom_pulse,
  output logic [BNC_CNT_W-1:0] bounce_count
);

  localparam logic [WIDTH-1:0] MaxVal = '1;
  localparam int unsigned      CntW   = $clog2(LOCK_N + 1);

  typedef enum logic [1:0] {StHunt, StSync, StLocked} state_e;

  state_e                 state_q, state_d;
  logic                   ref_dir_q, ref_dir_d;
  logic [WIDTH-1:0]       ref_val_q, ref_val_d;
  logic [CntW-1:0]        match_cnt_q, match_cnt_d, match_cnt_inc;
  logic                   locked_q, locked_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d, err_count_base;
  logic                   top_q, top_d;
  logic                   bottom_q, bottom_d;
  logic [BNC_CNT_W-1:0]   bounce_q, bounce_d;
  logic                   pred_dir;
  logic [WIDTH-1:0]       pred_val;
  logic                   match, hit;
`ifdef PING_PONG_CHECKER_STICKY_EN
  logic                   sticky_q, sticky_d;
`endif

  // Predicted successor; the counter reverses at the ends, so no wrap is ever expected.
  always_comb begin
    if (ref_dir_q) begin
      if (ref_val_q == MaxVal) begin
        pred_dir = 1'b0;
        pred_val = MaxVal - 1'b1;
      end else begin
        pred_dir = 1'b1;
        pred_val = ref_val_q + 1'b1;
      end
    end else if (ref_val_q == '0) begin
      pred_dir = 1'b1;
      pred_val = WIDTH'(1);
    end else begin
      pred_dir = 1'b0;
      pred_val = ref_val_q - 1'b1;
    end
  end

  assign match         = (in_dir == pred_dir) && (in_value == pred_val);
  assign match_cnt_inc = match_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ref_dir_d   = ref_dir_q;
    ref_val_d   = ref_val_q;
    match_cnt_d = match_cnt_q;
    err_d       = 1'b0;
    hit         = 1'b0;
    if (in_valid) begin
      ref_dir_d = in_dir;
      ref_val_d = in_value;
      unique case (state_q)
        StHunt: begin
          match_cnt_d = '0;
          state_d     = StSync;
        end
        StSync: begin
          if (match) begin
            match_cnt_d = match_cnt_inc;
            if (match_cnt_inc == CntW'(LOCK_N)) begin
              state_d = StLocked;
              hit     = 1'b1;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        StLocked: begin
          if (match) begin
            hit = 1'b1;
          end else begin
            err_d       = 1'b1;
            match_cnt_d = '0;
            state_d     = StSync;
          end
        end
        default: state_d = StHunt;
      endcase
    end
    locked_d = (state_d == StLocked);
    top_d    = hit && (in_value == MaxVal);
    bottom_d = hit && (in_value == '0);
    bounce_d = (top_d || bottom_d) ? bounce_q + 1'b1 : bounce_q;
  end

  // A clear and a new error in the same cycle leave the count at one.
  always_comb begin
    err_count_base = err_count_q;
`ifdef PING_PONG_CHECKER_STICKY_EN
    if (err_clr) err_count_base = '0;
    sticky_d = err_d | (sticky_q & ~err_clr);
`endif
    if (err_d && (err_count_base != '1)) err_count_d = err_count_base + 1'b1;
    else                                 err_count_d = err_count_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHunt;
      ref_dir_q   <= 1'b0;
      ref_val_q   <= '0;
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      top_q       <= 1'b0;
      bottom_q    <= 1'b0;
      bounce_q    <= '0;
`ifdef PING_PONG_CHECKER_STICKY_EN
      sticky_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ref_dir_q   <= ref_dir_d;
      ref_val_q   <= ref_val_d;
      match_cnt_q <= match_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      top_q       <= top_d;
      bottom_q    <= bottom_d;
      bounce_q    <= bounce_d;
`ifdef PING_PONG_CHECKER_STICKY_EN
      sticky_q    <= sticky_d;
`endif
    end
  end

  assign locked       = locked_q;
  assign err          = err_q;
  assign err_count    = err_count_q;
  assign top_pulse    = top_q;
  assign bottom_pulse = bottom_q;
  assign bounce_count = bounce_q;
`ifdef PING_PONG_CHECKER_STICKY_EN
  assign err_sticky   = sticky_q;
`endif

endmodule
